// File: rtl/aes_run_sched.sv
// Command sequencer for the aeses_lite core: optional key schedule, then a burst of
// triggered encryptions with each result returned over a valid/ready port.
module aes_run_sched #(
    parameter int AES_KW    = 256,
    parameter int AES_DW    = 128,
    parameter int CNT_BIT   = 16,
    parameter int TRIG_LEAD = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_new_key_i,
    input  logic                 cmd_chain_i,
    input  logic [0:AES_KW-1]    cmd_key_i,
    input  logic [AES_DW-1:0]    cmd_blk_i,
    input  logic [CNT_BIT-1:0]   cmd_repeat_i,
    input  logic                 abort_i,
    output logic [0:AES_KW-1]    aes_key_o,
    output logic [AES_DW-1:0]    aes_blk_o,
    output logic                 aes_sched_o,
    output logic                 aes_enable_o,
    input  logic [AES_DW-1:0]    aes_result_i,
    input  logic                 aes_valid_i,
    input  logic                 aes_ready_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [AES_DW-1:0]    res_data_o,
    output logic                 res_last_o,
    output logic                 trigger_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [CNT_BIT-1:0]   done_cnt_o
);

    typedef enum logic [2:0] {IDLE, KSCHED, KWAIT, PRE, FIRE, WAIT, OUT} state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t               state_reg;
    logic [7:0]           lead_reg;
    logic [WD_W-1:0]      wd_reg;
    logic [AES_DW-1:0]    blk_orig_reg;
    logic [CNT_BIT-1:0]   rep_reg;
    logic                 chain_reg;

    logic                 cmd_fire;
    logic                 stalled;
    logic                 wd_hit;
    logic                 lead_done;
    logic [CNT_BIT-1:0]   done_plus;

    assign cmd_fire  = cmd_valid_i && cmd_ready_o && !abort_i;
    assign wd_hit    = (wd_reg == WD_W'(TIMEOUT - 1));
    assign lead_done = (lead_reg == 8'(TRIG_LEAD - 1));
    assign done_plus = done_cnt_o + CNT_BIT'(1);
    assign busy_o    = (state_reg != IDLE);

    // Cycles that count towards the watchdog: waiting on core ready, or on the result.
    always_comb begin
        stalled = 1'b0;
        case (state_reg)
            KSCHED, KWAIT, PRE: stalled = !aes_ready_i;
            WAIT:               stalled = !aes_valid_i;
            default:            stalled = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            lead_reg     <= '0;
            wd_reg       <= '0;
            blk_orig_reg <= '0;
            rep_reg      <= '0;
            chain_reg    <= 1'b0;
            cmd_ready_o  <= 1'b1;
            aes_key_o    <= '0;
            aes_blk_o    <= '0;
            aes_sched_o  <= 1'b0;
            aes_enable_o <= 1'b0;
            res_valid_o  <= 1'b0;
            res_data_o   <= '0;
            res_last_o   <= 1'b0;
            trigger_o    <= 1'b0;
            err_o        <= 1'b0;
            done_cnt_o   <= '0;
        end else begin
            aes_sched_o  <= 1'b0;
            aes_enable_o <= 1'b0;
            if (abort_i && state_reg != IDLE) begin
                state_reg   <= IDLE;
                trigger_o   <= 1'b0;
                res_valid_o <= 1'b0;
                res_last_o  <= 1'b0;
                cmd_ready_o <= 1'b1;
                wd_reg      <= '0;
            end else if (stalled && wd_hit) begin
                state_reg   <= IDLE;
                err_o       <= 1'b1;
                trigger_o   <= 1'b0;
                cmd_ready_o <= 1'b1;
                wd_reg      <= '0;
            end else begin
                if (stalled) begin
                    wd_reg <= wd_reg + WD_W'(1);
                end
                case (state_reg)
                    IDLE: begin
                        if (cmd_fire) begin
                            aes_key_o    <= cmd_key_i;
                            aes_blk_o    <= cmd_blk_i;
                            blk_orig_reg <= cmd_blk_i;
                            rep_reg      <= (cmd_repeat_i == '0) ? CNT_BIT'(1) : cmd_repeat_i;
                            chain_reg    <= cmd_chain_i;
                            done_cnt_o   <= '0;
                            err_o        <= 1'b0;
                            cmd_ready_o  <= 1'b0;
                            lead_reg     <= '0;
                            wd_reg       <= '0;
                            if (cmd_new_key_i) begin
                                state_reg <= KSCHED;
                            end else begin
                                state_reg <= PRE;
                                trigger_o <= 1'b1;
                            end
                        end
                    end
                    KSCHED: begin
                        // The pulse is held in this state so KWAIT only starts once the core has seen it.
                        if (aes_sched_o) begin
                            state_reg <= KWAIT;
                            wd_reg    <= '0;
                        end else if (aes_ready_i) begin
                            aes_sched_o <= 1'b1;
                        end
                    end
                    KWAIT: begin
                        if (aes_ready_i) begin
                            state_reg <= PRE;
                            trigger_o <= 1'b1;
                            lead_reg  <= '0;
                            wd_reg    <= '0;
                        end
                    end
                    PRE: begin
                        if (aes_ready_i) begin
                            if (lead_done) begin
                                state_reg    <= FIRE;
                                aes_enable_o <= 1'b1;
                                wd_reg       <= '0;
                            end else begin
                                lead_reg <= lead_reg + 8'd1;
                            end
                        end
                    end
                    FIRE: begin
                        state_reg <= WAIT;
                        wd_reg    <= '0;
                    end
                    WAIT: begin
                        if (aes_valid_i) begin
                            res_data_o  <= aes_result_i;
                            res_valid_o <= 1'b1;
                            res_last_o  <= (done_plus == rep_reg);
                            trigger_o   <= 1'b0;
                            state_reg   <= OUT;
                            wd_reg      <= '0;
                        end
                    end
                    OUT: begin
                        if (res_ready_i) begin
                            res_valid_o <= 1'b0;
                            res_last_o  <= 1'b0;
                            done_cnt_o  <= (&done_cnt_o) ? done_cnt_o : done_plus;
                            if (res_last_o) begin
                                state_reg   <= IDLE;
                                cmd_ready_o <= 1'b1;
                            end else begin
                                state_reg <= PRE;
                                trigger_o <= 1'b1;
                                lead_reg  <= '0;
                                aes_blk_o <= chain_reg ? res_data_o : blk_orig_reg;
                            end
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        cmd_ready_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
